syn_board_io_ctrl: RTL and testbench

//  Parametrised board I/O controller: LEDs, seven-segment digits, pushbutton keys and toggle switches behind one local-bus slave.

---
 rtl/syn_board_io_pkg.sv | 38 +++
 rtl/syn_key_debounce.sv | 36 +++
 rtl/syn_board_io_ctrl.sv | 136 +++++++++++++
 tb/tb_syn_board_io_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/syn_board_io_pkg.sv
// Shared register map, blank pattern and seven-segment decode for the board I/O controller.
package syn_board_io_pkg;

  localparam logic [2:0] ADDR_LED_VAL    = 3'd0;
  localparam logic [2:0] ADDR_LED_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_HEX_VAL    = 3'd2;
  localparam logic [2:0] ADDR_HEX_EN     = 3'd3;
  localparam logic [2:0] ADDR_KEY_LVL    = 3'd4;
  localparam logic [2:0] ADDR_KEY_EVT    = 3'd5;
  localparam logic [2:0] ADDR_KEY_IRQ_EN = 3'd6;
  localparam logic [2:0] ADDR_SW_VAL     = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // Segments {g..a}, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    seg_decode = SEG_BLANK;
    case (v)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      4'hF: seg_decode = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/syn_key_debounce.sv
// One pushbutton: two-flop sync (inverted so 1 = pressed), stability counter,
// debounced level and a single-cycle pulse coincident with the level rising.
module syn_key_debounce #(
  parameter int P_DEBOUNCE_CYC = 500000
) (
  input  logic clk_ir,
  input  logic rst_ih,
  input  logic key_n_i,
  output logic key_lvl_o,
  output logic key_rise_o
);
  localparam int CW = (P_DEBOUNCE_CYC > 1) ? $clog2(P_DEBOUNCE_CYC) : 1;

  logic          sync0, sync1;
  logic [CW-1:0] cnt;
  logic          done;

  assign done       = (sync1 != key_lvl_o) && (cnt == CW'(P_DEBOUNCE_CYC - 1));
  assign key_rise_o = done & sync1;

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      cnt       <= '0;
      key_lvl_o <= 1'b0;
    end else begin
      sync0 <= ~key_n_i;
      sync1 <= sync0;
      // Any cycle where sync agrees with the level restarts the stability window.
      if (sync1 == key_lvl_o || done) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
      if (done) key_lvl_o <= sync1;
    end
  end
endmodule

// File: rtl/syn_board_io_ctrl.sv
// Board I/O controller: LED/blink, seven-seg digits, debounced keys with sticky
// events and interrupt, synchronised switches, all behind one local-bus slave.
module syn_board_io_ctrl
  import syn_board_io_pkg::*;
#(
  parameter int P_LB_DWIDTH    = 32,
  parameter int P_LB_AWIDTH    = 4,
  parameter int P_NUM_KEYS     = 4,
  parameter int P_NUM_SW       = 10,
  parameter int P_NUM_LEDS     = 18,
  parameter int P_NUM_HEX      = 4,
  parameter int P_DEBOUNCE_CYC = 500000,
  parameter int P_BLINK_DIV    = 25000000
) (
  input  logic                     clk_ir,
  input  logic                     rst_ih,
  input  logic                     lb_wr_en_i,
  input  logic                     lb_rd_en_i,
  input  logic [P_LB_AWIDTH-1:0]   lb_addr_i,
  input  logic [P_LB_DWIDTH-1:0]   lb_wr_data_i,
  output logic [P_LB_DWIDTH-1:0]   lb_rd_data_o,
  output logic                     lb_rd_valid_o,
  input  logic [P_NUM_KEYS-1:0]    key_n_i,
  input  logic [P_NUM_SW-1:0]      sw_i,
  output logic [P_NUM_LEDS-1:0]    led_o,
  output logic [7*P_NUM_HEX-1:0]   hex_o,
  output logic                     key_irq_o
);
  localparam int PW = (P_BLINK_DIV > 1) ? $clog2(P_BLINK_DIV) : 1;

  if (P_NUM_LEDS > P_LB_DWIDTH)    begin : g_chk_leds $error("P_NUM_LEDS exceeds P_LB_DWIDTH"); end
  if (P_NUM_HEX*4 > P_LB_DWIDTH)   begin : g_chk_hex  $error("P_NUM_HEX*4 exceeds P_LB_DWIDTH"); end
  if (P_NUM_KEYS > P_LB_DWIDTH || P_NUM_SW > P_LB_DWIDTH) begin : g_chk_io $error("key/switch count exceeds P_LB_DWIDTH"); end
  if (P_LB_AWIDTH < 3)             begin : g_chk_addr $error("P_LB_AWIDTH must cover 8 registers"); end

  logic [P_NUM_LEDS-1:0]  led_val_q, led_blink_q;
  logic [4*P_NUM_HEX-1:0] hex_val_q, hex_val_d;
  logic [P_NUM_HEX-1:0]   hex_en_q, hex_en_d;
  logic [7*P_NUM_HEX-1:0] hex_d;
  logic [P_NUM_KEYS-1:0]  key_lvl, key_rise, key_evt_q, key_evt_d, key_irq_en_q;
  logic [P_NUM_SW-1:0]    sw_sync0, sw_sync1;
  logic [PW-1:0]          blink_cnt;
  logic                   blink_phase;
  logic [P_LB_DWIDTH-1:0] rd_mux;
  logic                   addr_ok, wr_ok;
  logic [2:0]             sel;
  logic                   unused_wr;

  assign unused_wr = ^lb_wr_data_i;
  assign addr_ok   = (lb_addr_i >> 3) == '0;
  assign sel       = lb_addr_i[2:0];
  assign wr_ok     = lb_wr_en_i & addr_ok;

  for (genvar k = 0; k < P_NUM_KEYS; k++) begin : g_key
    syn_key_debounce #(.P_DEBOUNCE_CYC(P_DEBOUNCE_CYC)) u_db (
      .clk_ir    (clk_ir),
      .rst_ih    (rst_ih),
      .key_n_i   (key_n_i[k]),
      .key_lvl_o (key_lvl[k]),
      .key_rise_o(key_rise[k])
    );
  end

  // Next-state hex registers feed the decode so digits follow a write by one cycle.
  always_comb begin
    hex_val_d = hex_val_q;
    hex_en_d  = hex_en_q;
    key_evt_d = key_evt_q;
    if (wr_ok && sel == ADDR_HEX_VAL) hex_val_d = lb_wr_data_i[4*P_NUM_HEX-1:0];
    if (wr_ok && sel == ADDR_HEX_EN)  hex_en_d  = lb_wr_data_i[P_NUM_HEX-1:0];
    if (wr_ok && sel == ADDR_KEY_EVT) key_evt_d = key_evt_q & ~lb_wr_data_i[P_NUM_KEYS-1:0];
    key_evt_d = key_evt_d | key_rise;
  end

  for (genvar d = 0; d < P_NUM_HEX; d++) begin : g_hex
    assign hex_d[7*d +: 7] = hex_en_d[d] ? seg_decode(hex_val_d[4*d +: 4]) : SEG_BLANK;
  end

  always_comb begin
    rd_mux = '0;
    if (addr_ok) begin
      case (sel)
        ADDR_LED_VAL:    rd_mux = P_LB_DWIDTH'(led_val_q);
        ADDR_LED_BLINK:  rd_mux = P_LB_DWIDTH'(led_blink_q);
        ADDR_HEX_VAL:    rd_mux = P_LB_DWIDTH'(hex_val_q);
        ADDR_HEX_EN:     rd_mux = P_LB_DWIDTH'(hex_en_q);
        ADDR_KEY_LVL:    rd_mux = P_LB_DWIDTH'(key_lvl);
        ADDR_KEY_EVT:    rd_mux = P_LB_DWIDTH'(key_evt_q);
        ADDR_KEY_IRQ_EN: rd_mux = P_LB_DWIDTH'(key_irq_en_q);
        ADDR_SW_VAL:     rd_mux = P_LB_DWIDTH'(sw_sync1);
        default:         rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      led_val_q     <= '0;
      led_blink_q   <= '0;
      hex_val_q     <= '0;
      hex_en_q      <= '0;
      key_evt_q     <= '0;
      key_irq_en_q  <= '0;
      sw_sync0      <= '0;
      sw_sync1      <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      led_o         <= '0;
      hex_o         <= {P_NUM_HEX{SEG_BLANK}};
      key_irq_o     <= 1'b0;
      lb_rd_data_o  <= '0;
      lb_rd_valid_o <= 1'b0;
    end else begin
      if (wr_ok && sel == ADDR_LED_VAL)    led_val_q    <= lb_wr_data_i[P_NUM_LEDS-1:0];
      if (wr_ok && sel == ADDR_LED_BLINK)  led_blink_q  <= lb_wr_data_i[P_NUM_LEDS-1:0];
      if (wr_ok && sel == ADDR_KEY_IRQ_EN) key_irq_en_q <= lb_wr_data_i[P_NUM_KEYS-1:0];
      hex_val_q <= hex_val_d;
      hex_en_q  <= hex_en_d;
      key_evt_q <= key_evt_d;
      sw_sync0  <= sw_i;
      sw_sync1  <= sw_sync0;
      if (blink_cnt == PW'(P_BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      led_o     <= led_val_q & ~(led_blink_q & ~{P_NUM_LEDS{blink_phase}});
      hex_o     <= hex_d;
      key_irq_o <= |(key_evt_q & key_irq_en_q);
      // Read samples the registers before this cycle's write lands.
      lb_rd_valid_o <= lb_rd_en_i;
      if (lb_rd_en_i) lb_rd_data_o <= rd_mux;
    end
  end
endmodule

// File: tb/tb_syn_board_io_ctrl.sv
// Directed bench for syn_board_io_ctrl with short debounce and blink periods.
module tb_syn_board_io_ctrl;
  logic        clk = 1'b0;
  logic        rst_ih = 1'b1;
  logic        lb_wr_en = 1'b0, lb_rd_en = 1'b0;
  logic [3:0]  lb_addr = '0;
  logic [31:0] lb_wr_data = '0;
  logic [31:0] lb_rd_data;
  logic        lb_rd_valid;
  logic [3:0]  key_n = 4'hF;
  logic [9:0]  sw = '0;
  logic [17:0] led;
  logic [27:0] hex;
  logic        key_irq;
  int          total = 0, bad = 0, cyc = 0;

  syn_board_io_ctrl #(
    .P_DEBOUNCE_CYC(8),
    .P_BLINK_DIV   (4)
  ) dut (
    .clk_ir       (clk),
    .rst_ih       (rst_ih),
    .lb_wr_en_i   (lb_wr_en),
    .lb_rd_en_i   (lb_rd_en),
    .lb_addr_i    (lb_addr),
    .lb_wr_data_i (lb_wr_data),
    .lb_rd_data_o (lb_rd_data),
    .lb_rd_valid_o(lb_rd_valid),
    .key_n_i      (key_n),
    .sw_i         (sw),
    .led_o        (led),
    .hex_o        (hex),
    .key_irq_o    (key_irq)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; drives the blink-phase model.
  always @(posedge clk) begin
    if (rst_ih) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    lb_wr_en = 1'b1; lb_addr = a; lb_wr_data = d;
    tick();
    lb_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    lb_rd_en = 1'b1; lb_addr = a;
    tick();
    lb_rd_en = 1'b0;
    chk({tag, "_vld"}, 64'(lb_rd_valid), 64'd1);
    chk(tag, 64'(lb_rd_data), 64'(exp));
  endtask

  initial begin
    repeat (3) tick();
    rst_ih = 1'b0;
    chk("rst_hex", 64'(hex), 64'({7'h7f, 7'h7f, 7'h7f, 7'h7f}));
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_irq", 64'(key_irq), 64'd0);
    chk("rst_vld", 64'(lb_rd_valid), 64'd0);
    rd(4'd4, 32'd0, "rst_key_lvl");
    tick();
    chk("vld_pulse", 64'(lb_rd_valid), 64'd0);
    chk("rd_hold", 64'(lb_rd_data), 64'd0);

    // Hex decode and per-digit blanking
    wr(4'd2, 32'h3A1F);
    wr(4'd3, 32'hF);
    chk("hex_all", 64'(hex), 64'({7'h30, 7'h08, 7'h79, 7'h0E}));
    wr(4'd3, 32'h1);
    chk("hex_blank", 64'(hex), 64'({7'h7f, 7'h7f, 7'h7f, 7'h0E}));
    rd(4'd2, 32'h3A1F, "hex_val");

    // Switch sync, unmapped addresses, read/write collision
    sw = 10'h2A5;
    tick(); tick();
    rd(4'd7, 32'h2A5, "sw_val");
    wr(4'd8, 32'hFFFF_FFFF);
    rd(4'd0, 32'd0, "unmapped_wr");
    rd(4'd8, 32'd0, "unmapped_rd");
    lb_wr_en = 1'b1; lb_rd_en = 1'b1; lb_addr = 4'd0; lb_wr_data = 32'h3;
    tick();
    lb_wr_en = 1'b0; lb_rd_en = 1'b0;
    chk("rdwr_pre", 64'(lb_rd_data), 64'd0);
    rd(4'd0, 32'h3, "rdwr_post");

    // Short glitch must not move the level
    key_n = 4'b1101;
    repeat (3) tick();
    key_n = 4'hF;
    repeat (6) tick();
    rd(4'd4, 32'd0, "glitch");

    // Held press: level rises on the 10th edge after the pin change
    key_n = 4'b1101;
    repeat (9) tick();
    rd(4'd4, 32'd0, "lvl_early");
    rd(4'd4, 32'd2, "lvl_set");
    rd(4'd5, 32'd2, "evt_set");
    key_n = 4'hF;
    wr(4'd6, 32'd2);
    chk("irq_lag", 64'(key_irq), 64'd0);
    tick();
    chk("irq_on", 64'(key_irq), 64'd1);
    repeat (12) tick();

    // W1C landing on the same edge as a fresh rise: the set wins
    key_n = 4'b1101;
    repeat (9) tick();
    wr(4'd5, 32'd2);
    rd(4'd5, 32'd2, "evt_race");
    chk("irq_race", 64'(key_irq), 64'd1);
    wr(4'd5, 32'd2);
    chk("irq_hold", 64'(key_irq), 64'd1);
    tick();
    chk("irq_drop", 64'(key_irq), 64'd0);
    rd(4'd5, 32'd0, "evt_clr");
    rd(4'd4, 32'd2, "lvl_held");

    // Blink: led[0] steady, led[1] follows the free-running phase
    wr(4'd1, 32'h2);
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      chk("led0_steady", 64'(led[0]), 64'd1);
      chk("led1_blink", 64'(led[1]), 64'(((cyc - 1) >> 2) & 1));
      chk("led_hi_off", 64'(led[17:2]), 64'd0);
      tick();
    end

    // Reset in the middle of a debounce window
    key_n = 4'hF;
    repeat (12) tick();
    key_n = 4'b1101;
    repeat (7) tick();
    rst_ih = 1'b1;
    tick();
    rst_ih = 1'b0;
    chk("rst2_led", 64'(led), 64'd0);
    chk("rst2_hex", 64'(hex), 64'({7'h7f, 7'h7f, 7'h7f, 7'h7f}));
    chk("rst2_irq", 64'(key_irq), 64'd0);
    rd(4'd4, 32'd0, "rst2_lvl");
    rd(4'd5, 32'd0, "rst2_evt");
    repeat (7) tick();
    rd(4'd4, 32'd0, "rst2_lvl_early");
    rd(4'd4, 32'd2, "rst2_lvl_set");
    rd(4'd5, 32'd2, "rst2_evt_set");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
